// File: rtl/fod_pkg.sv
// Shared defaults and FSM encoding for the multiphase phase detector.
package fod_pkg;
  localparam int NSEG_BIN_DEF = 3;
  localparam int WF_PHASE_DEF = 24;
  localparam int AVG_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } fsm_state_e;
endpackage

// File: rtl/mp_edge_dec.sv
// Combinational 1->0 transition finder over a circular multiphase sample word.
// o_bad flags bubbles: zero edges or more than one edge in the word.
module mp_edge_dec #(
  parameter int NSEG_BIN = 3
) (
  input  logic [2**NSEG_BIN-1:0] i_samp,
  output logic [NSEG_BIN-1:0]    o_pos,
  output logic                   o_bad
);
  localparam int NSEG = 2**NSEG_BIN;

  logic [NSEG-1:0]   w_edge;
  logic [NSEG_BIN:0] w_cnt;

  always_comb begin
    w_edge = '0;
    w_cnt  = '0;
    o_pos  = '0;
    for (int i = 0; i < NSEG; i++) begin
      w_edge[i] = i_samp[i] & ~i_samp[(i + 1) % NSEG];
      if (w_edge[i]) begin
        w_cnt = w_cnt + (NSEG_BIN + 1)'(1);
        o_pos = NSEG_BIN'(i);
      end
    end
  end

  assign o_bad = (w_cnt != (NSEG_BIN + 1)'(1));
endmodule

// File: rtl/mp_phase_det.sv
// Multiphase-sampler phase detector: edge decode, wrapped phase error against the
// NCO tap, windowed error sum and bad-sample count, gated by an enable/settle FSM.
module mp_phase_det
  import fod_pkg::*;
#(
  parameter int NSEG_BIN   = NSEG_BIN_DEF,
  parameter int WF_PHASE   = WF_PHASE_DEF,
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int SETTLE_CYC = 4
) (
  input  logic                           CLK,
  input  logic                           ARST,
  input  logic                           EN,
  input  logic [2**NSEG_BIN-1:0]         PSAMP,
  input  logic [WF_PHASE-1:0]            NCO_PHASE,
  input  logic [NSEG_BIN-1:0]            PHASE_OFS,
  output logic [NSEG_BIN-1:0]            PHE,
  output logic                           PHE_VLD,
  output logic                           PHE_BAD,
  output logic signed [NSEG_BIN:0]       PHERR,
  output logic signed [NSEG_BIN+AVG_LOG2:0] ACC_OUT,
  output logic                           ACC_VLD,
  output logic [7:0]                     BAD_CNT,
  output fsm_state_e                     DBG_STATE
);
  localparam int ACC_W = NSEG_BIN + 1 + AVG_LOG2;
  localparam int SC_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  fsm_state_e              r_state;
  fsm_state_e              w_state_nxt;
  logic [SC_W-1:0]         r_settle_cnt;
  logic                    r_rst_q;
  logic                    w_samp_run;
  logic                    w_en_low;

  logic                    r_s1_run;
  logic [2**NSEG_BIN-1:0]  r_s1_samp;
  logic [NSEG_BIN-1:0]     r_s1_top;
  logic                    w_unused_nco;

  logic [NSEG_BIN-1:0]     w_pos;
  logic                    w_bad;
  logic [NSEG_BIN-1:0]     w_exp;
  logic [NSEG_BIN-1:0]     w_diff;
  logic signed [NSEG_BIN:0] w_pherr;
  logic signed [ACC_W-1:0] w_pherr_ext;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic                    w_proc;
  logic                    w_good;
  logic                    w_bad_smp;

  logic [NSEG_BIN-1:0]     r_phe;
  logic                    r_phe_vld;
  logic                    r_phe_bad;
  logic signed [NSEG_BIN:0] r_pherr;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_acc_out;
  logic                    r_acc_vld;
  logic [AVG_LOG2-1:0]     r_win_cnt;
  logic [7:0]              r_bad_cnt;

  // Holds the first edge after reset release idle so no sample is consumed on it.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) r_rst_q <= 1'b1;
    else      r_rst_q <= 1'b0;
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST)          r_state <= ST_IDLE;
    else if (!r_rst_q) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!EN) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = (SETTLE_CYC <= 1) ? ST_RUN : ST_SETTLE;
        ST_SETTLE: if (r_settle_cnt == SC_W'(SETTLE_CYC - 1)) w_state_nxt = ST_RUN;
        ST_RUN:    w_state_nxt = ST_RUN;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_samp_run = EN && (r_state == ST_RUN);
    w_en_low   = !EN;
  end

  // The IDLE->SETTLE edge already discards the first sample, so counting starts at 1.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      r_settle_cnt <= '0;
    end else if (!r_rst_q) begin
      if (!EN)                       r_settle_cnt <= '0;
      else if (r_state == ST_IDLE)   r_settle_cnt <= SC_W'(1);
      else if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      r_s1_run  <= 1'b0;
      r_s1_samp <= '0;
      r_s1_top  <= '0;
    end else if (!r_rst_q) begin
      r_s1_run  <= w_samp_run;
      r_s1_samp <= PSAMP;
      r_s1_top  <= NCO_PHASE[WF_PHASE-1 -: NSEG_BIN];
    end
  end

  assign w_unused_nco = ^NCO_PHASE[WF_PHASE-NSEG_BIN-1:0];

  mp_edge_dec #(.NSEG_BIN(NSEG_BIN)) u_edge_dec (
    .i_samp (r_s1_samp),
    .o_pos  (w_pos),
    .o_bad  (w_bad)
  );

  // Modular subtraction, then the same bits read as two's complement give the wrap.
  assign w_exp       = r_s1_top + PHASE_OFS;
  assign w_diff      = w_pos - w_exp;
  assign w_pherr     = {w_diff[NSEG_BIN-1], w_diff};
  assign w_pherr_ext = {{AVG_LOG2{w_pherr[NSEG_BIN]}}, w_pherr};
  assign w_acc_sum   = r_acc + w_pherr_ext;

  assign w_proc    = r_s1_run && EN;
  assign w_good    = w_proc && !w_bad;
  assign w_bad_smp = w_proc && w_bad;

  // PHE_VLD qualifies PHE/PHERR for exactly one cycle per good sample; there is no
  // backpressure, so a consumer must take the value on the cycle it is flagged.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      r_phe     <= '0;
      r_phe_vld <= 1'b0;
      r_phe_bad <= 1'b0;
      r_pherr   <= '0;
      r_acc     <= '0;
      r_acc_out <= '0;
      r_acc_vld <= 1'b0;
      r_win_cnt <= '0;
      r_bad_cnt <= '0;
    end else if (!r_rst_q) begin
      r_phe_vld <= w_good;
      r_phe_bad <= w_bad_smp;
      r_acc_vld <= 1'b0;
      if (w_good) begin
        r_phe   <= w_pos;
        r_pherr <= w_pherr;
        if (&r_win_cnt) begin
          r_acc_out <= w_acc_sum;
          r_acc_vld <= 1'b1;
          r_acc     <= '0;
          r_win_cnt <= '0;
        end else begin
          r_acc     <= w_acc_sum;
          r_win_cnt <= r_win_cnt + AVG_LOG2'(1);
        end
      end
      if (w_bad_smp && (r_bad_cnt != 8'hFF)) r_bad_cnt <= r_bad_cnt + 8'd1;
      if (w_en_low) begin
        r_acc     <= '0;
        r_win_cnt <= '0;
        r_bad_cnt <= '0;
      end
    end
  end

  assign PHE       = r_phe;
  assign PHE_VLD   = r_phe_vld;
  assign PHE_BAD   = r_phe_bad;
  assign PHERR     = r_pherr;
  assign ACC_OUT   = r_acc_out;
  assign ACC_VLD   = r_acc_vld;
  assign BAD_CNT   = r_bad_cnt;
  assign DBG_STATE = r_state;
endmodule
